// File: rtl/multidigit_display_ctrl_if.sv
// Host-side bundle of the multiplexed 7-segment controller: value capture handshake,
// display mode controls and the segment/digit-enable drive lines.
interface multidigit_display_ctrl_if #(
  parameter int NUM_DIGITS = 8,
  parameter int IN_WIDTH   = 32
);
  logic [IN_WIDTH-1:0]   Number;
  logic                  Load;
  logic                  HexMode;
  logic                  BlankLZ;
  logic                  Busy;
  logic                  Overflow;
  logic [6:0]            out7;
  logic [NUM_DIGITS-1:0] en_out;

  modport master (
    output Number, Load, HexMode, BlankLZ,
    input  Busy, Overflow, out7, en_out
  );

  modport slave (
    input  Number, Load, HexMode, BlankLZ,
    output Busy, Overflow, out7, en_out
  );
endinterface

// File: rtl/multidigit_display_ctrl.sv
// Multiplexed 7-segment controller: sequential binary-to-BCD (or hex pass-through) into a
// double-buffered digit bank, scanned one digit at a time with leading-zero blanking.
module multidigit_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int IN_WIDTH   = 32,
  parameter int DWELL_BITS = 17
) (
  input logic Clk,
  input logic Rst,
  multidigit_display_ctrl_if.slave bus
);
  // ceil(IN_WIDTH*log10(2)) in integer arithmetic
  localparam int BCD_DIGITS = (IN_WIDTH * 30103 + 99999) / 100000;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int DIG_W      = 4 * NUM_DIGITS;
  localparam int PAD_N      = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
  localparam int PAD_W      = 4 * PAD_N;
  localparam int CNT_W      = $clog2(IN_WIDTH);
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t               state_q, state_d;
  logic                 busy;
  logic [IN_WIDTH-1:0]  bin_q;
  logic [BCD_W-1:0]     bcd_q, bcd_adj, bcd_nxt;
  logic                 hex_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [PAD_W-1:0]     bcd_pad;
  logic [DIG_W-1:0]     hex_pad;
  logic [3:0]           commit_digit [NUM_DIGITS];
  logic                 commit_ovf;
  logic [3:0]           digit_q [NUM_DIGITS];
  logic                 ovf_q;
  logic [DWELL_BITS-1:0] dwell_q;
  logic [IDX_W-1:0]     idx_q;
  logic [NUM_DIGITS-1:0] blank, en_d, en_p1;
  logic                 zero_run;
  logic [3:0]           code_p1;

  function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < BCD_DIGITS; i++)
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    return r;
  endfunction

  // Segment order {a,b,c,d,e,f,g}, active-low (0 lights the segment)
  function automatic logic [6:0] seg7(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;  default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      IDLE:    if (bus.Load) state_d = bus.HexMode ? COMMIT : CONV;
      CONV: begin
        busy = 1'b1;
        if (bit_cnt_q == CNT_W'(IN_WIDTH - 1)) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: shift-add-3 conversion, one source bit per cycle
  assign bcd_adj = add3_adjust(bcd_q);
  assign bcd_nxt = (bcd_adj << 1) | BCD_W'(bin_q[IN_WIDTH-1]);

  always_ff @(posedge Clk) begin
    if (state_q == IDLE && bus.Load) begin
      bin_q     <= bus.Number;
      bcd_q     <= '0;
      hex_q     <= bus.HexMode;
      bit_cnt_q <= '0;
    end else if (state_q == CONV) begin
      bcd_q     <= bcd_nxt;
      bin_q     <= bin_q << 1;
      bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end

  always_comb begin
    commit_ovf = 1'b0;
    bcd_pad    = PAD_W'(bcd_q);
    hex_pad    = DIG_W'(bin_q);
    for (int i = 0; i < NUM_DIGITS; i++) commit_digit[i] = 4'h0;
    if (hex_q) begin
      for (int i = 0; i < NUM_DIGITS; i++) commit_digit[i] = hex_pad[4*i +: 4];
      for (int b = DIG_W; b < IN_WIDTH; b++)
        if (bin_q[b]) commit_ovf = 1'b1;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) commit_digit[i] = bcd_pad[4*i +: 4];
      for (int i = NUM_DIGITS; i < PAD_N; i++)
        if (bcd_pad[4*i +: 4] != 4'h0) commit_ovf = 1'b1;
    end
    if (commit_ovf)
      for (int i = 0; i < NUM_DIGITS; i++) commit_digit[i] = 4'hF;
  end

  // Stage p1: displayed bank, swapped in one cycle so the scan never sees a partial value
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 4'h0;
      ovf_q <= 1'b0;
    end else if (state_q == COMMIT) begin
      digit_q <= commit_digit;
      ovf_q   <= commit_ovf;
    end
  end

  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    en_d     = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (digit_q[i] == 4'h0);
      blank[i] = (i != 0) && bus.BlankLZ && !ovf_q && zero_run;
    end
    if (!blank[idx_q]) en_d[idx_q] = 1'b0;
  end

  // Stage p2: scan timing and registered digit drive
  always_ff @(posedge Clk) begin
    if (Rst) begin
      dwell_q <= '0;
      idx_q   <= '0;
      en_p1   <= '1;
      code_p1 <= 4'hF;
    end else begin
      dwell_q <= dwell_q + 1'b1;
      if (&dwell_q)
        idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      en_p1   <= en_d;
      code_p1 <= digit_q[idx_q];
    end
  end

  assign bus.Busy     = busy;
  assign bus.Overflow = ovf_q;
  assign bus.en_out   = en_p1;
  assign bus.out7     = seg7(code_p1);
endmodule

// File: tb/tb_multidigit_display_ctrl.sv
// Bench for the multiplexed display controller: an 8-digit and a 5-digit build with a
// fast scan, checked against an arithmetic model of digit values, overflow and blanking.
module tb_multidigit_display_ctrl;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  multidigit_display_ctrl_if #(.NUM_DIGITS(8), .IN_WIDTH(32)) b8 ();
  multidigit_display_ctrl_if #(.NUM_DIGITS(5), .IN_WIDTH(32)) b5 ();

  multidigit_display_ctrl #(.NUM_DIGITS(8), .IN_WIDTH(32), .DWELL_BITS(2)) dut8 (
    .Clk(Clk), .Rst(Rst), .bus(b8));
  multidigit_display_ctrl #(.NUM_DIGITS(5), .IN_WIDTH(32), .DWELL_BITS(2)) dut5 (
    .Clk(Clk), .Rst(Rst), .bus(b5));

  // Active-high {a..g} patterns, inverted for the active-low outputs
  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    logic [6:0] on;
    case (v)
      4'h0: on = 7'h7E; 4'h1: on = 7'h30; 4'h2: on = 7'h6D; 4'h3: on = 7'h79;
      4'h4: on = 7'h33; 4'h5: on = 7'h5B; 4'h6: on = 7'h5F; 4'h7: on = 7'h70;
      4'h8: on = 7'h7F; 4'h9: on = 7'h7B; 4'hA: on = 7'h77; 4'hB: on = 7'h1F;
      4'hC: on = 7'h4E; 4'hD: on = 7'h3D; 4'hE: on = 7'h4F; default: on = 7'h47;
    endcase
    return ~on;
  endfunction

  function automatic logic [31:0] ref_digits(input logic [31:0] num, input bit hex,
                                             input int nd, output bit ovf);
    logic [31:0] d;
    longint unsigned v;
    longint unsigned p;
    d = '0; v = num; p = 1; ovf = 0;
    for (int i = 0; i < 8; i++) begin
      if (hex) d[4*i +: 4] = num[4*i +: 4];
      else     d[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    if (hex) ovf = (nd < 8) && ((num >> (4*nd)) != 0);
    else begin
      p = 1;
      for (int i = 0; i < nd; i++) p = p * 10;
      ovf = (v >= p);
    end
    if (ovf) d = 32'hFFFF_FFFF;
    return d;
  endfunction

  function automatic bit ref_blank(input logic [31:0] d, input int i, input int nd,
                                   input bit blz, input bit ovf);
    if (i == 0 || !blz || ovf) return 1'b0;
    for (int j = i; j < nd; j++) if (d[4*j +: 4] != 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [7:0] en_of(input bit sel);
    return sel ? {3'b111, b5.en_out} : b8.en_out;
  endfunction
  function automatic logic [6:0] seg_of(input bit sel);
    return sel ? b5.out7 : b8.out7;
  endfunction
  function automatic logic busy_of(input bit sel);
    return sel ? b5.Busy : b8.Busy;
  endfunction
  function automatic logic ovf_of(input bit sel);
    return sel ? b5.Overflow : b8.Overflow;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic [31:0] num, input bit hex, input bit ld,
                       input bit blz);
    if (sel) begin
      b5.Number = num; b5.HexMode = hex; b5.Load = ld; b5.BlankLZ = blz;
    end else begin
      b8.Number = num; b8.HexMode = hex; b8.Load = ld; b8.BlankLZ = blz;
    end
  endtask

  task automatic load_wait(input bit sel, input logic [31:0] num, input bit hex,
                           input bit blz, output int nbusy);
    drive(sel, num, hex, 1'b1, blz);
    step();
    drive(sel, num, hex, 1'b0, blz);
    nbusy = 0;
    while (busy_of(sel) && nbusy < 100) begin
      nbusy++;
      step();
    end
    if (nbusy >= 100) begin
      checks++; errors++;
      $display("FAIL load_wait timeout: Busy high for %0d cycles, required low", nbusy);
    end
    step();
    step();
  endtask

  task automatic check_display(input bit sel, input logic [31:0] d, input bit blz,
                               input bit ovf, input string name);
    int nd;
    logic [7:0] seen;
    logic [7:0] en;
    int lows, idx;
    nd = sel ? 5 : 8;
    seen = '0;
    for (int c = 0; c < 8*nd; c++) begin
      en = en_of(sel); lows = 0; idx = 0;
      for (int i = 0; i < 8; i++) if (!en[i]) begin lows++; idx = i; end
      checks++;
      if (lows > 1) begin
        errors++;
        $display("FAIL %s onehot: en_out=%b, required at most one low bit", name, en);
      end else if (lows == 1) begin
        seen[idx] = 1'b1;
        checks++;
        if (idx >= nd || ref_blank(d, idx, nd, blz, ovf)) begin
          errors++;
          $display("FAIL %s blank: digit %0d enabled, required blanked", name, idx);
        end else if (seg_of(sel) !== seg_ref(d[4*idx +: 4])) begin
          errors++;
          $display("FAIL %s digit%0d: out7=%b required %b", name, idx, seg_of(sel),
                   seg_ref(d[4*idx +: 4]));
        end
      end
      step();
    end
    for (int i = 0; i < nd; i++) begin
      checks++;
      if (seen[i] !== !ref_blank(d, i, nd, blz, ovf)) begin
        errors++;
        $display("FAIL %s coverage digit%0d: shown=%0b required %0b", name, i, seen[i],
                 !ref_blank(d, i, nd, blz, ovf));
      end
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) step();
    checks++; if (b8.en_out !== 8'hFF) begin errors++; $display("FAIL reset en8: %h required ff", b8.en_out); end
    checks++; if (b5.en_out !== 5'h1F) begin errors++; $display("FAIL reset en5: %h required 1f", b5.en_out); end
    checks++; if (b8.Busy !== 1'b0 || b5.Busy !== 1'b0) begin errors++; $display("FAIL reset busy: %b%b required 00", b8.Busy, b5.Busy); end
    checks++; if (b8.Overflow !== 1'b0 || b5.Overflow !== 1'b0) begin errors++; $display("FAIL reset ovf: %b%b required 00", b8.Overflow, b5.Overflow); end
    Rst = 1'b0;
    step();
    checks++; if (b8.en_out !== 8'hFE) begin errors++; $display("FAIL first_enable: en8=%h required fe", b8.en_out); end
    checks++; if (b8.out7 !== seg_ref(4'h0)) begin errors++; $display("FAIL first_code: out7=%b required %b", b8.out7, seg_ref(4'h0)); end
  endtask

  // Called right after test_reset: sample k=1 is the first cycle after Rst dropped
  task automatic test_scan_seq();
    logic [4:0] e5;
    logic [7:0] e8;
    for (int k = 1; k <= 24; k++) begin
      e5 = 5'h1F; e5[((k-1)/4) % 5] = 1'b0;
      e8 = 8'hFF; e8[((k-1)/4) % 8] = 1'b0;
      checks++; if (b5.en_out !== e5) begin errors++; $display("FAIL scan5 k=%0d: en=%b required %b", k, b5.en_out, e5); end
      checks++; if (b8.en_out !== e8) begin errors++; $display("FAIL scan8 k=%0d: en=%b required %b", k, b8.en_out, e8); end
      step();
    end
  endtask

  task automatic test_decimal();
    int n; bit ovf; logic [31:0] d;
    d = ref_digits(32'd12345678, 1'b0, 8, ovf);
    load_wait(1'b0, 32'd12345678, 1'b0, 1'b0, n);
    checks++; if (n != 32) begin errors++; $display("FAIL dec busy_len: %0d required 32", n); end
    checks++; if (b8.Overflow !== 1'b0) begin errors++; $display("FAIL dec ovf: %b required 0", b8.Overflow); end
    check_display(1'b0, d, 1'b0, ovf, "dec");
  endtask

  task automatic test_overflow();
    int n; bit ovf; logic [31:0] d;
    drive(1'b0, 32'd100000000, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'd100000000, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (b8.Busy && n < 100) begin n++; step(); end
    checks++; if (n != 32) begin errors++; $display("FAIL ovf busy_len: %0d required 32", n); end
    checks++; if (b8.Overflow !== 1'b0) begin errors++; $display("FAIL ovf early: %b required 0 before commit", b8.Overflow); end
    step();
    checks++; if (b8.Overflow !== 1'b1) begin errors++; $display("FAIL ovf commit: %b required 1", b8.Overflow); end
    step();
    d = ref_digits(32'd100000000, 1'b0, 8, ovf);
    check_display(1'b0, d, 1'b0, ovf, "ovf");
    load_wait(1'b0, 32'd0, 1'b0, 1'b1, n);
    checks++; if (b8.Overflow !== 1'b0) begin errors++; $display("FAIL zero ovf: %b required 0", b8.Overflow); end
    check_display(1'b0, 32'd0, 1'b1, 1'b0, "zero");
  endtask

  task automatic test_hex();
    int n; bit ovf; logic [31:0] d;
    d = ref_digits(32'hDEADBEEF, 1'b1, 8, ovf);
    load_wait(1'b0, 32'hDEADBEEF, 1'b1, 1'b0, n);
    checks++; if (n != 0) begin errors++; $display("FAIL hex busy: %0d cycles required 0", n); end
    checks++; if (b8.Overflow !== 1'b0) begin errors++; $display("FAIL hex8 ovf: %b required 0", b8.Overflow); end
    check_display(1'b0, d, 1'b0, ovf, "hex8");
    d = ref_digits(32'hDEADBEEF, 1'b1, 5, ovf);
    load_wait(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, n);
    checks++; if (b5.Overflow !== 1'b1) begin errors++; $display("FAIL hex5 ovf: %b required 1", b5.Overflow); end
    check_display(1'b1, d, 1'b0, ovf, "hex5");
  endtask

  task automatic test_blanking();
    int n;
    load_wait(1'b0, 32'd305, 1'b0, 1'b1, n);
    check_display(1'b0, 32'h0000_0305, 1'b1, 1'b0, "blank305");
    b8.BlankLZ = 1'b0;
    step();
    check_display(1'b0, 32'h0000_0305, 1'b0, 1'b0, "noblank305");
  endtask

  task automatic test_load_ignored();
    int n;
    drive(1'b0, 32'd12345678, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'd12345678, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (b8.Busy && n < 100) begin
      n++;
      if (n == 5) drive(1'b0, 32'd87654321, 1'b0, 1'b1, 1'b0);
      if (n == 6) drive(1'b0, 32'd87654321, 1'b0, 1'b0, 1'b0);
      step();
    end
    checks++; if (n != 32) begin errors++; $display("FAIL ignore busy_len: %0d required 32", n); end
    step(); step();
    check_display(1'b0, 32'h1234_5678, 1'b0, 1'b0, "ignore");
  endtask

  task automatic test_abort();
    drive(1'b0, 32'd87654321, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'd87654321, 1'b0, 1'b0, 1'b0);
    repeat (10) step();
    checks++; if (b8.Busy !== 1'b1) begin errors++; $display("FAIL abort busy_mid: %b required 1", b8.Busy); end
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    checks++; if (b8.Busy !== 1'b0) begin errors++; $display("FAIL abort busy: %b required 0", b8.Busy); end
    checks++; if (b5.Overflow !== 1'b0) begin errors++; $display("FAIL abort ovf5: %b required 0", b5.Overflow); end
    step();
    check_display(1'b0, 32'd0, 1'b0, 1'b0, "abort8");
    check_display(1'b1, 32'd0, 1'b0, 1'b0, "abort5");
  endtask

  task automatic test_random();
    int n; bit ovf; bit sel, hex, blz; logic [31:0] num, d;
    for (int it = 0; it < 10; it++) begin
      sel = 1'($urandom_range(0, 1));
      hex = 1'($urandom_range(0, 1));
      blz = 1'($urandom_range(0, 1));
      num = $urandom >> $urandom_range(0, 31);
      d = ref_digits(num, hex, sel ? 5 : 8, ovf);
      load_wait(sel, num, hex, blz, n);
      checks++; if (n != (hex ? 0 : 32)) begin errors++; $display("FAIL rand%0d busy_len: %0d required %0d", it, n, hex ? 0 : 32); end
      checks++; if (ovf_of(sel) !== ovf) begin errors++; $display("FAIL rand%0d ovf: %b required %b (num=%0d hex=%0b)", it, ovf_of(sel), ovf, num, hex); end
      check_display(sel, d, blz, ovf, "rand");
    end
  endtask

  initial begin
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_scan_seq();
    test_decimal();
    test_overflow();
    test_hex();
    test_blanking();
    test_load_ignored();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
